// File: rtl/top_pkg.sv
// Shared types for the north bridge buffer read path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the chunk-size constant used to derive the module word width,
// the read sequencer FSM states and the sideband tags that travel with
// each read through the skid FIFO. The FIFO entry itself is declared in
// the read controller because its data field width follows that
// module's parameters.
package top_pkg;

    localparam int TOP_CHUNK_SIZE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // Beat position tags, produced at read-issue time.
    typedef struct packed {
        logic col_last;   // last row of the current column
        logic pass_last;  // last beat of the current pass
    } rd_tag_t;

endpackage

// File: rtl/buffer_n_skid_fifo.sv
// Purpose: 2-entry show-ahead FIFO with occupancy count.
// Latency: write visible at rd_dat/rd_vld the cycle after wr_vld.
// Backpressure: rd_rdy low holds the head stable; writer must not push when full.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr_vld, wr_dat    push strobe and entry (ignored while full)
//   rd_vld, rd_dat    head valid and head entry
//   rd_rdy            consumer accepts head this cycle
//   count             current occupancy, 0..2
module buffer_n_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         push;
    logic         pop;

    assign push   = wr_vld & (count_q != 2'd2);
    assign pop    = rd_vld & rd_rdy;
    assign rd_vld = (count_q != 2'd0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_dat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/buffer_n_rd_ctrl.sv
// Purpose: stream the north buffer tile out column-major as a valid/ready stream, NUM_PASSES sweeps per start.
// Latency: start at cycle 0 -> rd_en cycle 1 -> FIFO write cycle 2 -> m_valid cycle 3; 1 beat/cycle sustained.
// Backpressure: reads throttled so FIFO + in-flight never exceeds 2; head held stable while m_ready is low.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start                       one-cycle start pulse (ignored while busy)
//   busy, done                  run in progress / one-cycle completion pulse
//   rd_en, rd_addr, rd_data     bank port-B enable, address and read data (1-cycle latency)
//   m_valid, m_ready, m_data    output stream
//   m_col_last, m_pass_last     beat tags: last row of column / last beat of pass
//   stall_cnt                   only with BUFFER_N_RD_PERF_EN: busy cycles with m_valid & !m_ready
module buffer_n_rd_ctrl
    import top_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int NUM_CORES_B   = 1,
    parameter int TOTAL_INPUT_W = 2,
    parameter int ROW_X         = 16,
    parameter int COL_X         = 10,
    parameter int NUM_PASSES    = 3,
    localparam int MODULE_WIDTH = WIDTH * TOP_CHUNK_SIZE * NUM_CORES_B * TOTAL_INPUT_W,
    localparam int ADDR_WIDTH   = (ROW_X * COL_X > 1) ? $clog2(ROW_X * COL_X) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [MODULE_WIDTH-1:0] rd_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [MODULE_WIDTH-1:0] m_data,
    output logic                    m_col_last,
    output logic                    m_pass_last
`ifdef BUFFER_N_RD_PERF_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int ROW_W  = (ROW_X > 1) ? $clog2(ROW_X) : 1;
    localparam int COL_W  = (COL_X > 1) ? $clog2(COL_X) : 1;
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    typedef struct packed {
        logic [MODULE_WIDTH-1:0] data;
        rd_tag_t                 tag;
    } fifo_entry_t;

    rd_state_e             state_q;
    rd_state_e             state_d;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      col_q;
    logic [PASS_W-1:0]     pass_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  inflight_q;
    rd_tag_t               tag_q;
    logic                  done_q;
    logic                  drain_done;

    logic                  row_last;
    logic                  col_last;
    logic                  pass_final;
    logic                  pop;
    logic [1:0]            fifo_count;
    logic [2:0]            occ;
    logic                  issue_ok;

    fifo_entry_t           wr_entry;
    fifo_entry_t           head;

    assign row_last   = (row_q == ROW_W'(ROW_X - 1));
    assign col_last   = (col_q == COL_W'(COL_X - 1));
    assign pass_final = (pass_q == PASS_W'(NUM_PASSES - 1));

    // Occupancy the FIFO will have next cycle, counting the read already
    // in flight. Keeping it below 2 before issuing guarantees the FIFO is
    // never written while full, even if the consumer stalls indefinitely.
    assign pop      = m_valid & m_ready;
    assign occ      = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue_ok = (occ < 3'd2);

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rd_addr = addr_q;

    always_comb begin
        state_d    = state_q;
        rd_en      = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                rd_en = issue_ok;
                if (issue_ok && row_last && col_last && pass_final) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Nothing left after this cycle's pop: the final beat is
                // being accepted now, so done lands on the next cycle.
                if (occ == 3'd0) begin
                    state_d    = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= drain_done;
        end
    end

    // Column-major walk. Address steps by COL_X down a column; a column
    // wrap restarts at the top of the next column (address = column index),
    // and the final wrap leaves every counter at zero for the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q      <= '0;
            col_q      <= '0;
            pass_q     <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= rd_en;
            if (rd_en) begin
                tag_q.col_last  <= row_last;
                tag_q.pass_last <= row_last & col_last;
                if (row_last) begin
                    row_q <= '0;
                    if (col_last) begin
                        col_q  <= '0;
                        addr_q <= '0;
                        pass_q <= pass_final ? '0 : pass_q + 1'b1;
                    end else begin
                        col_q  <= col_q + 1'b1;
                        addr_q <= ADDR_WIDTH'(col_q) + 1'b1;
                    end
                end else begin
                    row_q  <= row_q + 1'b1;
                    addr_q <= addr_q + ADDR_WIDTH'(COL_X);
                end
            end
        end
    end

    assign wr_entry.data = rd_data;
    assign wr_entry.tag  = tag_q;

    buffer_n_skid_fifo #(
        .W ($bits(fifo_entry_t))
    ) u_skid_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (inflight_q),
        .wr_dat (wr_entry),
        .rd_vld (m_valid),
        .rd_dat (head),
        .rd_rdy (m_ready),
        .count  (fifo_count)
    );

    assign m_data      = head.data;
    assign m_col_last  = head.tag.col_last;
    assign m_pass_last = head.tag.pass_last;

`ifdef BUFFER_N_RD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state_q == IDLE) && start) begin
            stall_cnt <= '0;
        end else if (busy && m_valid && !m_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_buffer_n_rd_ctrl.sv
module tb_buffer_n_rd_ctrl;
    import top_pkg::*;

    localparam int ROW_X      = 4;
    localparam int COL_X      = 3;
    localparam int NUM_PASSES = 2;
    localparam int MW         = 16 * TOP_CHUNK_SIZE * 1 * 2;
    localparam int AW         = $clog2(ROW_X * COL_X);
    localparam int PASS_BEATS = ROW_X * COL_X;
    localparam int BEATS      = PASS_BEATS * NUM_PASSES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic [MW-1:0] rd_data = '0;
    logic          busy, done, rd_en, m_valid, m_col_last, m_pass_last;
    logic [AW-1:0] rd_addr;
    logic [MW-1:0] m_data;
`ifdef BUFFER_N_RD_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    buffer_n_rd_ctrl #(
        .WIDTH(16), .NUM_CORES_B(1), .TOTAL_INPUT_W(2),
        .ROW_X(ROW_X), .COL_X(COL_X), .NUM_PASSES(NUM_PASSES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_col_last(m_col_last), .m_pass_last(m_pass_last)
`ifdef BUFFER_N_RD_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Bank model: word at each address holds its own address, 1-cycle read.
    always @(posedge clk) begin
        if (rd_en) rd_data <= MW'(rd_addr);
    end

    typedef struct packed {
        logic [MW-1:0] data;
        logic          cl;
        logic          pl;
    } beat_t;

    typedef struct {
        logic start;
        logic ready;
        logic e_rd_en;
        int   e_addr;
        logic e_valid;
        int   e_data;
        logic e_cl;
        logic e_pl;
        logic e_busy;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    int    c = 0;
    int    mode = 0;
    int    dup_start = -1;
    int    done_cnt = 0;
    int    done_cyc = -1;
    int    last_acc = -1;
    int    stall_rd = 0;
    beat_t q_beat[$];
    int    q_addr[$];
    vec_t  tbl[8];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, c);
        end
    endtask

    function automatic vec_t mk(logic s, logic r, logic en, int a, logic v, int d,
                                logic cl, logic pl, logic b);
        vec_t t;
        t.start = s; t.ready = r; t.e_rd_en = en; t.e_addr = a; t.e_valid = v;
        t.e_data = d; t.e_cl = cl; t.e_pl = pl; t.e_busy = b;
        return t;
    endfunction

    function automatic int exp_addr(int k);
        int p;
        p = k % PASS_BEATS;
        return (p % ROW_X) * COL_X + (p / ROW_X);
    endfunction

    task automatic clear_log();
        q_beat.delete();
        q_addr.delete();
        done_cnt = 0; done_cyc = -1; last_acc = -1; stall_rd = 0; c = 0; dup_start = -1;
    endtask

    task automatic sample();
        if (rd_en) begin
            q_addr.push_back(int'(rd_addr));
            if (mode == 1 && c <= 10) stall_rd++;
        end
        if (mode == 1 && c <= 10 && m_valid) chk("stall_hold_data", 160'(m_data), 160'(0));
        if (m_valid && m_ready) begin
            q_beat.push_back('{m_data, m_col_last, m_pass_last});
            last_acc = c;
        end
        if (done) begin
            done_cnt++;
            done_cyc = c;
        end
    endtask

    task automatic step();
        start = (c == 0) || (c == dup_start);
        case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (c > 10);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic run_to_done(input int budget);
        while (c < budget && !(done_cnt > 0 && c > done_cyc + 3)) step();
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        start = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        chk(name, 160'({rd_en, rd_addr, m_valid, m_data, busy, done, m_col_last, m_pass_last}), 160'(0));
`ifdef BUFFER_N_RD_PERF_EN
        chk({name, "_stall_cnt"}, 160'(stall_cnt), 160'(0));
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_stream(input string name);
        beat_t e;
        chk({name, "_beat_count"}, 160'(q_beat.size()), 160'(BEATS));
        chk({name, "_read_count"}, 160'(q_addr.size()), 160'(BEATS));
        for (int k = 0; k < q_beat.size() && k < BEATS; k++) begin
            e.data = MW'(exp_addr(k));
            e.cl   = ((k % ROW_X) == ROW_X - 1);
            e.pl   = ((k % PASS_BEATS) == PASS_BEATS - 1);
            chk({name, "_beat"}, 160'(q_beat[k]), 160'(e));
        end
        for (int k = 0; k < q_addr.size() && k < BEATS; k++)
            chk({name, "_rd_addr"}, 160'(q_addr[k]), 160'(exp_addr(k)));
        chk({name, "_done_once"}, 160'(done_cnt), 160'(1));
        chk({name, "_done_after_last_accept"}, 160'(done_cyc - last_acc), 160'(1));
    endtask

    initial begin
        // Cycle-by-cycle opening of a run with m_ready held high.
        tbl[0] = mk(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        tbl[2] = mk(1'b0, 1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        tbl[3] = mk(1'b0, 1'b1, 1'b1, 6, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        tbl[4] = mk(1'b0, 1'b1, 1'b1, 9, 1'b1, 3, 1'b0, 1'b0, 1'b1);
        tbl[5] = mk(1'b0, 1'b1, 1'b1, 1, 1'b1, 6, 1'b0, 1'b0, 1'b1);
        tbl[6] = mk(1'b0, 1'b1, 1'b1, 4, 1'b1, 9, 1'b1, 1'b0, 1'b1);
        tbl[7] = mk(1'b0, 1'b1, 1'b1, 7, 1'b1, 1, 1'b0, 1'b0, 1'b1);

        do_reset("reset_initial");

        // Scenario 1: full throughput, table for the opening cycles.
        mode = 0;
        clear_log();
        for (int i = 0; i < 8; i++) begin
            c = i;
            start = tbl[i].start;
            m_ready = tbl[i].ready;
            @(negedge clk);
            chk("tbl_rd_en", 160'(rd_en), 160'(tbl[i].e_rd_en));
            if (tbl[i].e_rd_en) chk("tbl_rd_addr", 160'(rd_addr), 160'(tbl[i].e_addr));
            chk("tbl_m_valid", 160'(m_valid), 160'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk("tbl_m_data", 160'(m_data), 160'(tbl[i].e_data));
                chk("tbl_tags", 160'({m_col_last, m_pass_last}), 160'({tbl[i].e_cl, tbl[i].e_pl}));
            end
            chk("tbl_busy", 160'(busy), 160'(tbl[i].e_busy));
            sample();
            @(posedge clk); #1;
        end
        c = 8;
        run_to_done(100);
        check_stream("full_rate");
        chk("full_rate_done_cycle", 160'(done_cyc), 160'(27));

        // Scenario 2: consumer stalled for cycles 0..10.
        do_reset("reset_before_stall");
        mode = 1;
        clear_log();
        run_to_done(200);
        chk("stall_rd_en_pulses", 160'(stall_rd), 160'(2));
        check_stream("stall");
`ifdef BUFFER_N_RD_PERF_EN
        chk("stall_cnt", 160'(stall_cnt), 160'(8));
`endif

        // Scenario 3: random ready.
        do_reset("reset_before_random");
        mode = 2;
        clear_log();
        run_to_done(400);
        check_stream("random_ready");

        // Scenario 4: reset after the fifth beat, then a clean run.
        do_reset("reset_before_midrun");
        mode = 0;
        clear_log();
        while (q_beat.size() < 5 && c < 50) step();
        chk("midrun_reached_beat5", 160'(q_beat.size()), 160'(5));
        do_reset("reset_midrun");
        clear_log();
        run_to_done(100);
        check_stream("after_midrun_reset");

        // Scenario 5: start pulsed again while busy.
        do_reset("reset_before_dup_start");
        mode = 0;
        clear_log();
        dup_start = 5;
        run_to_done(100);
        check_stream("dup_start");
        chk("dup_start_done_cycle", 160'(done_cyc), 160'(27));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
